// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// word addresses on the system-ID slave and default build-time expectations.
package kernel_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ID_REQ  = 3'd1,
        ST_RD_ID_WAIT = 3'd2,
        ST_RD_TS_REQ  = 3'd3,
        ST_RD_TS_WAIT = 3'd4,
        ST_DONE       = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID      = 32'h0000_0001;
    localparam logic [31:0] SYSID_DEFAULT_TS      = 32'd1531299496;
    localparam int unsigned SYSID_DEFAULT_TIMEOUT = 255;

    // States that present a read request on the bus.
    function automatic logic sysid_is_req(input sysid_state_e s);
        return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
    endfunction

    // States that belong to an outstanding word read (request or response phase).
    function automatic logic sysid_in_read(input sysid_state_e s);
        return sysid_is_req(s) || (s == ST_RD_ID_WAIT) || (s == ST_RD_TS_WAIT);
    endfunction

endpackage

// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface kernel_sysid_checker_if;

    // A request is accepted on any cycle with avm_read=1 and avm_waitrequest=0;
    // the matching response is the next avm_readdatavalid pulse, at least one
    // cycle later, with avm_readdata valid only while avm_readdatavalid=1.
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/kernel_sysid_timeout.sv
// Per-word watchdog: counts cycles spent on one read and flags the cycle in
// which the count reaches the configured limit.
module kernel_sysid_timeout (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (enable_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // count_q holds the cycles already completed, so the current cycle is
    // count_q+1; expiry fires during the limit-th cycle of the read.
    assign expired_o = enable_i && (({1'b0, count_q} + 17'd1) >= {1'b0, limit_i});

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/kernel_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words
// and reports whether the running hardware image matches the expected build.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES     = SYSID_DEFAULT_TIMEOUT,
    parameter int          AUTO_START         = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    kernel_sysid_checker_if.master        avm,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timeout_err,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value,
    output sysid_state_e                  dbg_state_o
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    sysid_state_e state_q, state_d;
    logic         first_q;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         tmo_err_q, tmo_err_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;

    logic         tmo_clear;
    logic         tmo_enable;
    logic         tmo_expired;
    logic         accepted;
    logic         launch;

    assign accepted   = sysid_is_req(state_q) && !avm.avm_waitrequest;
    assign tmo_enable = sysid_in_read(state_q);

    // The auto-launch only applies to the first cycle after reset release;
    // first_q is dropped on every non-reset edge.
    assign launch = start || ((AUTO_START != 0) && first_q && (state_q == ST_IDLE));

    kernel_sysid_timeout u_timeout (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .limit_i   (TMO_LIMIT),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        tmo_err_d  = tmo_err_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        tmo_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d    = ST_RD_ID_REQ;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    tmo_err_d  = 1'b0;
                    id_value_d = 32'd0;
                    ts_value_d = 32'd0;
                    tmo_clear  = 1'b1;
                end
            end

            ST_RD_ID_REQ: begin
                if (tmo_expired) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    tmo_err_d = 1'b1;
                end else if (accepted) begin
                    state_d = ST_RD_ID_WAIT;
                end
            end

            // A response landing in the expiry cycle still counts as success.
            ST_RD_ID_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    state_d    = ST_RD_TS_REQ;
                    id_value_d = avm.avm_readdata;
                    id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
                    tmo_clear  = 1'b1;
                end else if (tmo_expired) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    tmo_err_d = 1'b1;
                end
            end

            ST_RD_TS_REQ: begin
                if (tmo_expired) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    tmo_err_d = 1'b1;
                end else if (accepted) begin
                    state_d = ST_RD_TS_WAIT;
                end
            end

            ST_RD_TS_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ts_value_d = avm.avm_readdata;
                    ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
                end else if (tmo_expired) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    tmo_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            tmo_err_q  <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            first_q    <= 1'b0;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            tmo_err_q  <= tmo_err_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm.avm_read    = sysid_is_req(state_q);
    assign avm.avm_address = (state_q == ST_RD_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_err_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Randomised bench for kernel_sysid_checker: a configurable Avalon slave plus a
// cycle-count model of each check's outcome derived from the read timings.
module tb_kernel_sysid_checker;
    import kernel_sysid_pkg::*;

    localparam int          T      = 8;
    localparam logic [31:0] EXP_ID = 32'h0000_0001;
    localparam logic [31:0] EXP_TS = 32'd1531299496;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0]  id_value, ts_value;
    sysid_state_e dbg_state;

    kernel_sysid_checker_if bus ();

    kernel_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T),
        .AUTO_START         (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- Avalon slave model ----------------
    bit          slave_en = 1'b1;
    int          cfg_w[2];
    int          cfg_l[2];
    bit          cfg_drop[2];
    logic [31:0] cfg_word[2];
    int          stall_n = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          reads[2];
    bit          addr_glitch = 1'b0;
    bit          last_stalled = 1'b0;
    logic        last_addr = 1'b0;

    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clock);
            if (slave_en) begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = $urandom();
                if (pend) begin
                    if (pend_cnt <= 1) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata      = pend_data;
                        pend = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end
                if (last_stalled && bus.avm_read && (bus.avm_address != last_addr)) addr_glitch = 1'b1;
                last_stalled = 1'b0;
                if (bus.avm_read) begin
                    int a;
                    a = int'(bus.avm_address);
                    if (stall_n < cfg_w[a]) begin
                        bus.avm_waitrequest = 1'b1;
                        stall_n++;
                        last_stalled = 1'b1;
                        last_addr = bus.avm_address;
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                        stall_n = 0;
                        reads[a]++;
                        if (!cfg_drop[a]) begin
                            pend      = 1'b1;
                            pend_cnt  = cfg_l[a];
                            pend_data = cfg_word[a];
                        end
                    end
                end else begin
                    bus.avm_waitrequest = 1'($urandom_range(0, 1));
                    stall_n = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_slave(input int w0, l0, w1, l1, input logic [31:0] id, ts,
                             input bit drop0, drop1);
        cfg_w[0] = w0; cfg_l[0] = l0; cfg_w[1] = w1; cfg_l[1] = l1;
        cfg_word[0] = id; cfg_word[1] = ts;
        cfg_drop[0] = drop0; cfg_drop[1] = drop1;
        reads[0] = 0; reads[1] = 0;
        stall_n = 0; addr_glitch = 1'b0; last_stalled = 1'b0;
    endtask

    // One full check: program the slave, pulse start, optionally poke start
    // again while busy, then compare against the timing-derived expectation.
    task automatic run_check(input string tag, input int w0, l0, w1, l1,
                             input logic [31:0] id, ts, input bit drop0, drop1,
                             input int busy_poke);
        int  e, d0, d1, exp_edges, erd_id, erd_ts;
        bit  id_to, ts_to, eok_id, eok_ts, eto;
        logic [31:0] ev_id, ev_ts;

        // expected outcome: a word succeeds iff its data lands within T cycles
        d0 = w0 + 1 + l0;
        d1 = w1 + 1 + l1;
        id_to  = drop0 || (d0 > T);
        erd_id = (w0 + 1 <= T) ? 1 : 0;
        if (id_to) begin
            exp_edges = T; ev_id = '0; ev_ts = '0; eok_id = 0; eok_ts = 0; eto = 1; erd_ts = 0;
        end else begin
            ev_id  = id;
            eok_id = (id == EXP_ID);
            ts_to  = drop1 || (d1 > T);
            erd_ts = (w1 + 1 <= T) ? 1 : 0;
            if (ts_to) begin
                exp_edges = d0 + T; ev_ts = '0; eok_ts = 0; eto = 1;
            end else begin
                exp_edges = d0 + d1; ev_ts = ts; eok_ts = (ts == EXP_TS); eto = 0;
            end
        end
        exp_q.push_back(ev_id);
        exp_q.push_back(ev_ts);

        @(posedge clock); #1;
        set_slave(w0, l0, w1, l1, id, ts, drop0, drop1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, ":busy_on_launch"}, 32'(busy), 32'd1);
        check({tag, ":flags_cleared"}, {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
        check({tag, ":values_cleared"}, id_value | ts_value, 32'd0);

        e = 0;
        while (!done && e < 60) begin
            @(posedge clock); #1;
            e++;
            start = (busy_poke != 0 && e == busy_poke) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, ":done_edge"}, 32'(e), 32'(exp_edges));
        check({tag, ":busy_off"}, 32'(busy), 32'd0);
        check({tag, ":id_ok"}, 32'(id_ok), 32'(eok_id));
        check({tag, ":ts_ok"}, 32'(ts_ok), 32'(eok_ts));
        check({tag, ":timeout_err"}, 32'(timeout_err), 32'(eto));
        check({tag, ":id_value"}, id_value, exp_q.pop_front());
        check({tag, ":ts_value"}, ts_value, exp_q.pop_front());
        check({tag, ":avm_read_idle"}, 32'(bus.avm_read), 32'd0);
        check({tag, ":id_reads"}, 32'(reads[0]), 32'(erd_id));
        check({tag, ":ts_reads"}, 32'(reads[1]), 32'(erd_ts));
        check({tag, ":addr_stable"}, 32'(addr_glitch), 32'd0);

        // late responses must not disturb the held result
        repeat (16) @(posedge clock);
        #1;
        check({tag, ":held"}, {31'd0, done} ^ id_value ^ {ts_value[31:1], ts_value[0] ^ timeout_err},
              {31'd0, 1'b1} ^ ev_id ^ {ev_ts[31:1], ev_ts[0] ^ eto});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e;
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 0, 0);

        // reset state, then auto-start on release
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset:outputs", {25'd0, busy, done, id_ok, ts_ok, timeout_err,
              bus.avm_read, bus.avm_address}, 32'd0);
        check("reset:values", id_value | ts_value, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("auto:first_read", {30'd0, bus.avm_read, bus.avm_address}, 32'd2);
        e = 0;
        while (!done && e < 60) begin @(posedge clock); #1; e++; end
        check("auto:done_edge", 32'(e), 32'd4);
        check("auto:ok", {30'd0, id_ok, ts_ok}, 32'd3);
        check("auto:values", id_value ^ ts_value, EXP_ID ^ EXP_TS);
        repeat (4) @(posedge clock);

        // directed cases, including the exact-limit boundary
        run_check("zero_wait",  0, 1, 0, 1, EXP_ID, EXP_TS,          0, 0, 0);
        run_check("stall3_lat2", 3, 2, 3, 2, EXP_ID, EXP_TS,         0, 0, 0);
        run_check("ts_mismatch", 0, 1, 0, 1, EXP_ID, EXP_TS + 32'd1, 0, 0, 0);
        run_check("id_no_rsp",   0, 1, 0, 1, EXP_ID, EXP_TS,         1, 0, 0);
        run_check("ts_no_rsp",   1, 1, 0, 1, EXP_ID, EXP_TS,         0, 1, 0);
        run_check("id_at_limit", 3, 4, 0, 1, EXP_ID, EXP_TS,         0, 0, 0);
        run_check("id_past_lim", 3, 5, 0, 1, EXP_ID, EXP_TS,         0, 0, 0);
        run_check("ts_stall_to", 0, 1, 8, 1, 32'hCAFE_0001, EXP_TS,  0, 0, 0);
        run_check("start_busy",  1, 1, 1, 1, EXP_ID, EXP_TS,         0, 0, 2);
        run_check("restart",     0, 1, 0, 1, EXP_ID, 32'h1234_5678,  0, 0, 0);

        // reset during RD_TS_WAIT with a stale response after release
        @(posedge clock); #1;
        set_slave(0, 1, 0, 6, EXP_ID, EXP_TS, 0, 0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        e = 0;
        while (dbg_state != ST_RD_TS_WAIT && e < 40) begin @(posedge clock); #1; e++; end
        check("rst:in_ts_wait", 32'(dbg_state), 32'(ST_RD_TS_WAIT));
        reset_n = 1'b0;
        slave_en = 1'b0;
        pend = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        @(posedge clock); #1;
        check("rst:outputs", {25'd0, busy, done, id_ok, ts_ok, timeout_err,
              bus.avm_read, bus.avm_address}, 32'd0);
        check("rst:values", id_value | ts_value, 32'd0);
        check("rst:state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        check("rst:relaunch", {30'd0, bus.avm_read, bus.avm_address}, 32'd2);
        bus.avm_waitrequest = 1'b1;
        @(posedge clock); #1;
        check("rst:stale_ignored", id_value, 32'd0);
        bus.avm_readdatavalid = 1'b0;
        bus.avm_waitrequest = 1'b0;
        set_slave($urandom_range(0, 2), 1, 0, 1, EXP_ID, EXP_TS, 0, 0);
        slave_en = 1'b1;
        e = 0;
        while (!done && e < 60) begin @(posedge clock); #1; e++; end
        check("rst:fresh_ok", {28'd0, done, id_ok, ts_ok, timeout_err}, 32'he);
        check("rst:fresh_values", id_value ^ ts_value, EXP_ID ^ EXP_TS);
        check("rst:single_reads", 32'(reads[0] * 16 + reads[1]), 32'd17);
        repeat (16) @(posedge clock);

        // randomised timings and payloads
        for (int i = 0; i < 24; i++) begin
            logic [31:0] rid, rts;
            rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom();
            rts = ($urandom_range(0, 2) == 0) ? EXP_TS + 32'($urandom_range(0, 1)) :
                  (($urandom_range(0, 1) == 0) ? EXP_TS : $urandom());
            run_check($sformatf("rand%0d", i),
                      $urandom_range(0, 5), $urandom_range(1, 6),
                      $urandom_range(0, 5), $urandom_range(1, 6),
                      rid, rts,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_sysid_checker.md
Name: kernel_sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its two words.
- Word 0 is the system ID; word 1 is the build timestamp.
- Each check reads both words, compares them against build-time expected values and reports match/mismatch/timeout flags.
- Boot logic and the host status register use these flags to refuse operation on a mismatched hardware image.

Parameters:
- EXPECTED_ID, 32'h0000_0001, required value of word 0.
- EXPECTED_TIMESTAMP, 32'd1531299496, required value of word 1.
- TIMEOUT_CYCLES, 255, max cycles per read (request + response) before abort; range 1..65535.
- AUTO_START, 1, if 1 a check launches automatically on the first cycle after reset release.

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  launch a check; sampled only in IDLE or DONE.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave/fabric stall; request accepted on the cycle avm_read=1 and avm_waitrequest=0.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  response strobe; latency ≥1 cycle after acceptance.
- busy  out  1  check in progress.
- done  out  1  check finished; held until next start or reset.
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE, every output 0, timeout counter 0. This holds even mid-transaction.
- After reset, responses still in flight for a read that was already accepted are ignored, because IDLE ignores avm_readdatavalid.
- FSM states: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, DONE.
- IDLE: go to RD_ID_REQ if start=1, or on the first post-reset cycle when AUTO_START=1.
- Entering RD_ID_REQ from IDLE or DONE clears done, id_ok, ts_ok, timeout_err, id_value and ts_value, and sets busy=1.
- *_REQ states: avm_read=1, with avm_address = 0 (ID) or 1 (TS); address held stable while waitrequest=1. On acceptance, move to the matching *_WAIT state and deassert avm_read next cycle.
- *_WAIT states: avm_read=0.
  - When avm_readdatavalid=1, capture avm_readdata into id_value or ts_value and evaluate the compare the same edge.
  - RD_ID_WAIT then goes to RD_TS_REQ; RD_TS_WAIT then goes to DONE.
  - avm_readdatavalid in any non-WAIT state is ignored.
- Timeout counter:
  - Cleared on entry to each *_REQ state; increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without the awaited event (acceptance plus valid), go to DONE with timeout_err=1, avm_read=0, and the ok flag for the unfinished word left 0.
  - An ID timeout skips the TS read.
  - If readdatavalid arrives on the same cycle as the timeout, the data wins and the timeout is not flagged.
- DONE: busy=0, done=1; flags stable. start=1 restarts the check (same cycle semantics as from IDLE).
- start while busy is ignored; no queuing.
- Zero-wait latency: start high at edge N gives avm_read=1 in cycle N+1. If readdatavalid follows one cycle after each acceptance, done=1 at edge N+5.
- Compares are full 32-bit equality; no masking.

Decomposition:
- Package kernel_sysid_pkg holds:
  - state enum;
  - constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - default expected values.
- One sub-module, kernel_sysid_timeout: a 16-bit counter with clear, enable and limit inputs and an expired output.

Test Plan:
- Zero-wait slave returning 1 / 1531299496, start pulse at cycle 0 → avm_address sequence 0 then 1; done=1 at cycle 5; id_ok=1, ts_ok=1, timeout_err=0; id_value=1, ts_value=1531299496.
- waitrequest held high 3 cycles on each read, readdatavalid latency 2 → address stable during stall; exactly one accepted read per word; done with both ok=1.
- Slave returns timestamp 1531299497 → id_ok=1, ts_ok=0, done=1, ts_value=1531299497.
- TIMEOUT_CYCLES=8, ID read never gets readdatavalid → timeout_err=1 on the 8th REQ/WAIT cycle; no TS read issued; id_ok=ts_ok=0; avm_read=0.
- reset_n=0 during RD_TS_WAIT, then stale readdatavalid arrives after release → all outputs 0; stale data not captured; AUTO_START=1 relaunches with a fresh ID read.
- start pulsed while busy, then again in DONE → first ignored (single ID read observed); second clears flags and reruns the full sequence.
